// File: rtl/dp_arbiter.sv
// Two-requester round-robin arbiter that captures one instruction word at a time and
// sequences it through the controller's start/waiting handshake. Define DP_ARB_TIMEOUT_EN for the watchdog.
`timescale 1ns/1ps
module dp_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [15:0] instr0,
    input  logic [15:0] instr1,
    output logic [1:0]  grant,
    output logic [1:0]  done,
    output logic [15:0] instr_out,
    output logic        start,
    input  logic        waiting,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t      state, state_d;
    logic [1:0]  grant_d, done_d;
    logic [15:0] instr_d;
    logic        start_d, busy_d;
    logic        owner, owner_d;
    logic        last_served, last_d;
    logic        winner;

`ifdef DP_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd_cnt, wd_d;
    logic          wd_expire;
    logic          err_d;

    // Count value TIMEOUT-1 on a wait-state edge means TIMEOUT cycles have elapsed.
    assign wd_expire = (wd_cnt == CW'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign err = 1'b0;
`endif

    // A lone requester wins outright; on a tie the one not served last wins.
    assign winner = (req == 2'b11) ? ~last_served : req[1];

    always_comb begin
        state_d = state;
        grant_d = 2'b00;
        done_d  = 2'b00;
        start_d = 1'b0;
        instr_d = instr_out;
        owner_d = owner;
        last_d  = last_served;
`ifdef DP_ARB_TIMEOUT_EN
        wd_d    = wd_cnt;
        err_d   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (waiting && (req != 2'b00)) begin
                    grant_d = winner ? 2'b10 : 2'b01;
                    instr_d = winner ? instr1 : instr0;
                    owner_d = winner;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                start_d = 1'b1;
                state_d = WAIT_BUSY;
`ifdef DP_ARB_TIMEOUT_EN
                wd_d    = '0;
`endif
            end
            WAIT_BUSY: begin
`ifdef DP_ARB_TIMEOUT_EN
                wd_d = wd_cnt + CW'(1);
                if (wd_expire) begin
                    err_d   = 1'b1;
                    last_d  = owner;
                    state_d = IDLE;
                end else
`endif
                if (!waiting) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
`ifdef DP_ARB_TIMEOUT_EN
                wd_d = wd_cnt + CW'(1);
                // Watchdog takes precedence over a completion seen on the same edge.
                if (wd_expire) begin
                    err_d   = 1'b1;
                    last_d  = owner;
                    state_d = IDLE;
                end else
`endif
                if (waiting) begin
                    done_d  = owner ? 2'b10 : 2'b01;
                    last_d  = owner;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= 2'b00;
            done        <= 2'b00;
            start       <= 1'b0;
            busy        <= 1'b0;
            instr_out   <= 16'h0000;
            owner       <= 1'b0;
            last_served <= 1'b1;
        end else begin
            state       <= state_d;
            grant       <= grant_d;
            done        <= done_d;
            start       <= start_d;
            busy        <= busy_d;
            instr_out   <= instr_d;
            owner       <= owner_d;
            last_served <= last_d;
        end
    end

`ifdef DP_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            wd_cnt <= wd_d;
            err    <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_dp_arbiter.sv
// Scoreboarded bench for dp_arbiter: drivers push expected grants/completions, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_dp_arbiter;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [15:0] instr0 = 16'h0, instr1 = 16'h0;
    logic        waiting = 1'b0;
    logic [1:0]  grant, done;
    logic [15:0] instr_out;
    logic        start, busy, err;

    always #5 clk = ~clk;

    dp_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .instr0(instr0), .instr1(instr1),
        .grant(grant), .done(done), .instr_out(instr_out), .start(start),
        .waiting(waiting), .busy(busy), .err(err)
    );

    typedef struct { bit w; logic [15:0] ins; } gexp_t;
    typedef struct { bit is_err; bit w; } dexp_t;
    gexp_t gq[$];
    dexp_t dq[$];

    int checks = 0;
    int errors = 0;
    int ls = 1;             // reference model: index of last-served requester
    bit exp_start = 1'b0;
    logic [15:0] held = 16'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every grant/done/err the DUT shows must match the head of its queue.
    always @(negedge clk) begin : mon
        gexp_t g;
        dexp_t d;
        if (!rst_n) begin
            exp_start = 1'b0;
            held      = 16'h0;
        end else begin
            if (start || exp_start) chk("start_after_grant", start, exp_start);
            exp_start = (grant != 2'b00);
            if (grant != 2'b00) begin
                if (gq.size() == 0) chk("unexpected_grant", grant, 0);
                else begin
                    g = gq.pop_front();
                    chk("grant", grant, g.w ? 2'b10 : 2'b01);
                    chk("instr_out_at_grant", instr_out, g.ins);
                    held = g.ins;
                end
            end else begin
                chk("instr_out_hold", instr_out, held);
            end
            if (done != 2'b00 || err) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", done, 0);
                    chk("unexpected_err", err, 0);
                end else begin
                    d = dq.pop_front();
                    chk("done", done, d.is_err ? 2'b00 : (d.w ? 2'b10 : 2'b01));
                    chk("err", err, d.is_err);
                    chk("busy_at_end", busy, 0);
                end
            end
        end
    end

    // One full transaction; d = cycles after start before waiting drops, h = cycles it stays low.
    task automatic txn(input logic [1:0] r, input logic [15:0] a, input logic [15:0] b,
                       input int d, input int h, input int pre_idle);
        int w, k;
        bit exp_err;
        w = (r == 2'b11) ? 1 - ls : (r[1] ? 1 : 0);
        exp_err = 1'b0;
`ifdef DP_ARB_TIMEOUT_EN
        exp_err = (d + h + 1 >= TO);
`endif
        gq.push_back(gexp_t'{w[0], (w == 1) ? b : a});
        dq.push_back(dexp_t'{exp_err, w[0]});
        ls = w;
        req = r; instr0 = a; instr1 = b;
        if (pre_idle > 0) begin
            waiting = 1'b0;
            repeat (pre_idle) begin
                tick();
                chk("no_grant_while_not_waiting", grant, 0);
            end
        end
        waiting = 1'b1;
        k = 0;
        do begin tick(); k++; end while (grant == 2'b00 && k < 20);
        chk("grant_seen", grant != 2'b00, 1);
        if (r != 2'b11) req = 2'b00;
        instr0 = 16'($urandom);
        instr1 = 16'($urandom);
        tick();
        k = 0;
        while (done == 2'b00 && !err && k < 60) begin
            if (k == d) waiting = 1'b0;
            if (k == d + h) waiting = 1'b1;
            tick();
            k++;
        end
        chk("end_seen", (done != 2'b00) || err, 1);
        if (exp_err) chk("err_latency", k, TO);
        else         chk("done_latency", k, d + h + 1);
        waiting = 1'b1;
        req = 2'b00;
    endtask

    initial begin
        // reset state
        rst_n = 1'b0; waiting = 1'b1;
        repeat (3) tick();
        chk("rst_grant", grant, 0); chk("rst_done", done, 0); chk("rst_start", start, 0);
        chk("rst_busy", busy, 0); chk("rst_err", err, 0); chk("rst_instr_out", instr_out, 0);
        rst_n = 1'b1;
        tick();

        txn(2'b01, 16'hA5C3, 16'h1111, 1, 2, 0);
        txn(2'b01, 16'h0F0F, 16'h2222, 0, 1, 4);
        txn(2'b10, 16'h3333, 16'hBEEF, 2, 5, 0);

        // a request withdrawn before any grant is never served
        req = 2'b01; instr0 = 16'h7777; waiting = 1'b0;
        repeat (3) tick();
        req = 2'b00; waiting = 1'b1;
        repeat (5) begin tick(); chk("withdrawn_req_no_grant", grant, 0); end

        // reset while in WAIT_DONE abandons the transaction
        gq.push_back(gexp_t'{1'b0, 16'hC0DE});
        req = 2'b01; instr0 = 16'hC0DE; waiting = 1'b1;
        begin
            int k;
            k = 0;
            do begin tick(); k++; end while (grant == 2'b00 && k < 20);
            chk("rst_txn_grant_seen", grant != 2'b00, 1);
        end
        req = 2'b00;
        tick();
        waiting = 1'b0;
        tick(); tick();
        rst_n = 1'b0; ls = 1;
        tick();
        chk("midrst_grant", grant, 0); chk("midrst_done", done, 0); chk("midrst_start", start, 0);
        chk("midrst_busy", busy, 0); chk("midrst_err", err, 0); chk("midrst_instr_out", instr_out, 0);
        tick();
        rst_n = 1'b1; waiting = 1'b1;
        tick(); tick();

        // continuous tie alternates, requester 0 first after reset
        for (int i = 0; i < 4; i++) txn(2'b11, 16'h1000 + 16'(i), 16'h2000 + 16'(i), 1, 1, 0);

`ifdef DP_ARB_TIMEOUT_EN
        // watchdog abort, then the other requester wins the next tie
        txn(2'b11, 16'hDEAD, 16'hFACE, 0, 30, 0);
        txn(2'b11, 16'h4444, 16'h5555, 1, 1, 0);
`endif

        for (int i = 0; i < 20; i++)
            txn(2'($urandom_range(1, 3)), 16'($urandom), 16'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), int'($urandom_range(0, 1)));

        repeat (4) tick();
        chk("grant_queue_drained", gq.size(), 0);
        chk("done_queue_drained", dq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end
endmodule
